udma_filter_rx_arbiter: RTL

UDMA_FILTER_RX_ARBITER -- requirements
Module: udma_filter_rx_arbiter

---
 rtl/udma_filter_rx_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/udma_filter_rx_arbiter.sv
// Round-robin arbiter merging filter dataout beats into one registered uDMA RX channel stage.
// Optional macro UDMA_FILTER_ARB_BURST_EN keeps a requester locked until its req_last_i beat.
module udma_filter_rx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int L2_AWIDTH_NOAL = 15,
  localparam int SRC_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     resetn_i,
  input  logic [N_REQ-1:0][L2_AWIDTH_NOAL-1:0]     req_addr_i,
  input  logic [N_REQ-1:0][1:0]                    req_datasize_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]         req_data_i,
  input  logic [N_REQ-1:0]                         req_last_i,
  input  logic [N_REQ-1:0]                         req_valid_i,
  output logic [N_REQ-1:0]                         req_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0]                rx_ch_addr_o,
  output logic [1:0]                               rx_ch_datasize_o,
  output logic [DATA_WIDTH-1:0]                    rx_ch_data_o,
  output logic                                     rx_ch_valid_o,
  input  logic                                     rx_ch_ready_i,
  output logic [SRC_W-1:0]                         rx_ch_src_o
);

  logic             s_load;
  logic [N_REQ-1:0] s_eligible;
  logic             s_win_found;
  logic [SRC_W-1:0] s_win_idx;
  logic [SRC_W-1:0] s_prio_next;
  logic [SRC_W-1:0] r_prio;

  assign s_load = ~rx_ch_valid_o | rx_ch_ready_i;

`ifdef UDMA_FILTER_ARB_BURST_EN
  logic             r_locked;
  logic [SRC_W-1:0] r_lock_idx;

  // While a burst is open only its owner may be granted
  always_comb begin
    s_eligible = '0;
    if (r_locked) begin
      s_eligible[r_lock_idx] = req_valid_i[r_lock_idx];
    end else begin
      s_eligible = req_valid_i;
    end
  end

  // Burst lock tracking: opened by a non-last beat, closed by the owner's last beat
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (s_load && s_win_found) begin
      r_locked   <= ~req_last_i[s_win_idx];
      r_lock_idx <= s_win_idx;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last_i;
  assign s_eligible  = req_valid_i;
`endif

  // Scan downward so the final overwrite is the first eligible index upward from r_prio
  always_comb begin
    int               sum;
    logic [SRC_W-1:0] cand;
    s_win_found = 1'b0;
    s_win_idx   = '0;
    sum         = 0;
    cand        = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum         = int'(r_prio) + i;
      cand        = SRC_W'((sum >= N_REQ) ? (sum - N_REQ) : sum);
      s_win_idx   = s_eligible[cand] ? cand : s_win_idx;
      s_win_found = s_win_found | s_eligible[cand];
    end
  end

  assign s_prio_next = (s_win_idx == SRC_W'(N_REQ - 1)) ? '0 : (s_win_idx + SRC_W'(1));

  // One-hot ready to the winner, held low during reset
  always_comb begin
    req_ready_o = '0;
    if (resetn_i && s_load && s_win_found) begin
      req_ready_o[s_win_idx] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Output stage and rotating priority pointer
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rx_ch_valid_o    <= 1'b0;
      rx_ch_addr_o     <= '0;
      rx_ch_datasize_o <= 2'b00;
      rx_ch_data_o     <= '0;
      rx_ch_src_o      <= '0;
      r_prio           <= '0;
    end else if (s_load) begin
      if (s_win_found) begin
        rx_ch_valid_o    <= 1'b1;
        rx_ch_addr_o     <= req_addr_i[s_win_idx];
        rx_ch_datasize_o <= req_datasize_i[s_win_idx];
        rx_ch_data_o     <= req_data_i[s_win_idx];
        rx_ch_src_o      <= s_win_idx;
`ifdef UDMA_FILTER_ARB_BURST_EN
        if (req_last_i[s_win_idx]) begin
          r_prio <= s_prio_next;
        end
`else
        r_prio <= s_prio_next;
`endif
      end else begin
        rx_ch_valid_o <= 1'b0;
      end
    end
  end

endmodule
